// File: rtl/note_mixer.sv
// rtl/note_mixer.sv - sums up to MAX_VOICES pressed note levels into one saturated sample per period
module note_mixer #(
  parameter int SAMPLE_DIV = 1134,
  parameter int MAX_VOICES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [575:0] notes,
  input  logic [35:0]  keys,
  output logic [15:0]  sample,
  output logic         sample_valid,
  output logic [5:0]   voices,
  output logic         clipped
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [15:0] TICK_AT     = 16'(SAMPLE_DIV - 1);
  localparam logic [5:0]  VOICE_LIMIT = 6'(MAX_VOICES);
  localparam logic [5:0]  LAST_IDX    = 6'd35;

  state_t       state;
  state_t       state_next;
  logic [15:0]  cnt;
  logic         started;
  logic         tick;
  logic [35:0]  snap;
  logic [5:0]   idx;
  logic [21:0]  acc;
  logic [5:0]   vc;
  logic [15:0]  note_cur;
  logic         take;
  logic [21:0]  acc_sum;
  logic [5:0]   vc_sum;
  logic         last;

  assign tick     = (cnt == TICK_AT);
  assign last     = (state == SCAN) && (idx == LAST_IDX);
  assign note_cur = notes[{idx, 4'b0000} +: 16];
  assign take     = snap[idx] && (vc < VOICE_LIMIT);
  assign acc_sum  = acc + (take ? {6'd0, note_cur} : 22'd0);
  assign vc_sum   = vc + (take ? 6'd1 : 6'd0);

  // Free-running sample divider; it holds at 0 on the first edge after reset so
  // the first tick edge lands SAMPLE_DIV cycles after that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 16'd0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (started) begin
        cnt <= tick ? 16'd0 : cnt + 16'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a tick starts a 36-cycle scan, the last index ends it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (tick) state_next = SCAN;
      SCAN: if (idx == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Scan datapath: snapshot keys at the tick, accumulate one note per cycle,
  // publish the saturated result on the edge that finishes index 35.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap         <= 36'd0;
      idx          <= 6'd0;
      acc          <= 22'd0;
      vc           <= 6'd0;
      sample       <= 16'd0;
      sample_valid <= 1'b0;
      voices       <= 6'd0;
      clipped      <= 1'b0;
    end else begin
      sample_valid <= last;
      if (state == IDLE && tick) begin
        snap <= keys;
        idx  <= 6'd0;
        acc  <= 22'd0;
        vc   <= 6'd0;
      end else if (state == SCAN) begin
        acc <= acc_sum;
        vc  <= vc_sum;
        idx <= idx + 6'd1;
        if (idx == LAST_IDX) begin
          sample  <= (|acc_sum[21:16]) ? 16'hFFFF : acc_sum[15:0];
          voices  <= vc_sum;
          clipped <= |acc_sum[21:16];
        end
      end
    end
  end

endmodule

// File: doc/note_mixer.md
NOTE_MIXER -- requirements
Module: note_mixer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1134, meaning clk cycles per output sample; legal range 38..65535.
REQ-002 SHALL have parameter MAX_VOICES, default 4, meaning maximum simultaneously summed notes; legal range 1..36.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port notes, input, 576, 36 packed 16-bit note levels from the note generator; note i at bits [16i+15:16i], i=0 is C1 through i=35 is B3 (chromatic order, octaves 1..3).
REQ-006 SHALL have port keys, input, 36, key-pressed flags, bit i enables note i.
REQ-007 SHALL have port sample, output, 16, mixed unsigned audio sample.
REQ-008 SHALL have port sample_valid, output, 1, one-cycle strobe marking a new sample.
REQ-009 SHALL have port voices, output, 6, number of notes summed into the current sample.
REQ-010 SHALL have port clipped, output, 1, saturation occurred in the current sample.

Function
REQ-011 SHALL run a free-running tick counter 0..SAMPLE_DIV-1, wrapping to 0; tick is the cycle the counter equals SAMPLE_DIV-1, independent of FSM state.
REQ-012 SHALL implement FSM states IDLE and SCAN; IDLE->SCAN on tick; SCAN->IDLE after index 35 is processed; no other transitions.
REQ-013 SHALL snapshot keys into an internal register at the tick edge; key changes during SCAN SHALL not affect the sample in progress.
REQ-014 SHALL in SCAN process one note per cycle, index 0 to 35 ascending (36 cycles), clearing the accumulator and voice count at the tick edge.
REQ-015 SHALL add notes[i] to a 22-bit accumulator and increment the voice count only if snapshot bit i is 1 and the voice count is below MAX_VOICES; pressed keys beyond the limit (higher index) SHALL be dropped.
REQ-016 SHALL sample notes[i] live in the cycle index i is processed (not snapshotted).
REQ-017 SHALL at the edge ending index 35 load sample with the final sum saturated to 16'hFFFF, load voices with the final count, load clipped with 1 if the unsaturated sum exceeded 16'hFFFF else 0.
REQ-018 SHALL assert sample_valid for exactly one cycle, the cycle after the index-35 edge; latency from tick cycle to sample_valid high is 37 cycles.
REQ-019 SHALL hold sample, voices, clipped stable between strobes.
REQ-020 SHALL output sample=0, voices=0, clipped=0 for a scan with no snapshot keys set.
REQ-021 SHALL produce exactly one sample_valid per SAMPLE_DIV cycles in steady state.

Reset
REQ-022 SHALL on rst=1 immediately force: tick counter 0, state IDLE, accumulator 0, voice count 0, key snapshot 0, sample 0, sample_valid 0, voices 0, clipped 0.
REQ-023 SHALL on reset asserted mid-SCAN abort the scan with no sample_valid; after release, the first tick occurs SAMPLE_DIV cycles after the first rising clk edge with rst=0.

Verification
REQ-024 SHALL verify single note: SAMPLE_DIV=40, keys bit 9 set, notes[9]=16'h3FFF, others 16'h1234 -> sample_valid every 40 cycles, 37 cycles after tick; sample=16'h3FFF, voices=1, clipped=0.
REQ-025 SHALL verify voice limit: MAX_VOICES=4, keys bits 0,5,10,20,30 set, all notes 16'h1000 -> sample=16'h4000, voices=4 (bit 30 dropped), clipped=0.
REQ-026 SHALL verify saturation: MAX_VOICES=36, all keys set, all notes 16'h3FFF -> sample=16'hFFFF, voices=36, clipped=1; next sample with keys=0 -> sample=0, voices=0, clipped=0.
REQ-027 SHALL verify snapshot: keys bit 3 set at tick, changed to bit 4 during SCAN, notes[3]=16'h0100, notes[4]=16'h0200 -> sample=16'h0100; next sample=16'h0200.
REQ-028 SHALL verify live note sampling: notes[35] changed from 16'h0000 to 16'h1FFF at scan cycle 10, key 35 set -> sample=16'h1FFF.
REQ-029 SHALL verify mid-scan reset: rst pulsed at scan index 20 -> all outputs 0 immediately, no sample_valid for that scan, next sample_valid exactly SAMPLE_DIV+37 cycles after release.
